// File: rtl/costas_lock_ctrl.sv
// -----------------------------------------------------------------------------
// costas_lock_ctrl
//
// Lock supervisor for a Costas carrier-recovery loop. It averages |phase_err|
// over windows of 2^WIN_LOG2 valid samples, counts consecutive good/bad
// windows, and sequences the loop through IDLE -> CLEAR -> ACQUIRE -> TRACK,
// with FAIL on an acquisition timeout. It also selects the loop-filter gains
// and pulses nco_clr to flush the integrator/NCO before each acquisition.
//
// Ports
//   CLK_IN     in   1   clock for all logic
//   RESET      in   1   asynchronous, active-high reset
//   start      in   1   pulse: begin (re)acquisition from CLEAR
//   abort      in   1   pulse: return to IDLE (highest priority)
//   err_valid  in   1   qualifies phase_err, one sample per high cycle
//   phase_err  in  12   signed phase detector output
//   nco_clr    out  1   clears loop-filter integrator and NCO phase
//   kp_shift   out  4   proportional gain right-shift
//   ki_shift   out  4   integral gain right-shift
//   locked     out  1   carrier lock indication
//   acq_fail   out  1   acquisition timeout flag
//   state      out  3   IDLE=0, CLEAR=1, ACQUIRE=2, TRACK=3, FAIL=4
// -----------------------------------------------------------------------------
module costas_lock_ctrl #(
  parameter int unsigned WIN_LOG2    = 8,
  parameter int unsigned LOCK_THR    = 64,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned UNLOCK_CNT  = 2,
  parameter int unsigned ACQ_TIMEOUT = 64,
  parameter int unsigned CLR_CYCLES  = 16,
  parameter logic [3:0]  ACQ_KP      = 4'd4,
  parameter logic [3:0]  ACQ_KI      = 4'd8,
  parameter logic [3:0]  TRK_KP      = 4'd7,
  parameter logic [3:0]  TRK_KI      = 4'd12
) (
  input  logic               CLK_IN,
  input  logic               RESET,
  input  logic               start,
  input  logic               abort,
  input  logic               err_valid,
  input  logic signed [11:0] phase_err,
  output logic               nco_clr,
  output logic [3:0]         kp_shift,
  output logic [3:0]         ki_shift,
  output logic               locked,
  output logic               acq_fail,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_TRACK   = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  // 2^WIN_LOG2 samples of at most 2047 always fit in 11+WIN_LOG2 bits.
  localparam int ACC_W  = 11 + WIN_LOG2;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam int WIN_W  = $clog2(ACQ_TIMEOUT + 1);
  localparam int CLR_W  = $clog2(CLR_CYCLES + 1);

  // One extra bit so the shifted threshold cannot overflow the compare.
  localparam logic [ACC_W:0] GOOD_LIMIT = (ACC_W + 1)'(LOCK_THR) << WIN_LOG2;

  state_t              cur;
  logic [10:0]         abs_err;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [WIN_LOG2-1:0] smp_cnt;
  logic [GOOD_W-1:0]   good_cnt;
  logic [BAD_W-1:0]    bad_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [CLR_W-1:0]    clr_cnt;

  logic in_loop, win_end, win_good;
  logic lock_hit, timeout_hit, unlock_hit, clr_done;

  assign state = cur;

  // Saturating magnitude: -2048 has no positive 12-bit counterpart, clamp it.
  always_comb begin
    // NOTE: default first so every path assigns abs_err and no latch is inferred.
    abs_err = phase_err[10:0];
    if (phase_err == 12'sh800)
      abs_err = 11'h7FF;
    else if (phase_err[11])
      abs_err = ~phase_err[10:0] + 11'd1;
  end

  assign in_loop  = (cur == ST_ACQUIRE) || (cur == ST_TRACK);
  assign acc_sum  = acc + ACC_W'(abs_err);
  // The window-ending sample is part of the sum that is judged.
  assign win_end  = err_valid && in_loop && (&smp_cnt);
  assign win_good = {1'b0, acc_sum} < GOOD_LIMIT;

  assign lock_hit    = win_good && ((good_cnt + 1'b1) == GOOD_W'(LOCK_CNT));
  assign timeout_hit = (win_cnt + 1'b1) == WIN_W'(ACQ_TIMEOUT);
  assign unlock_hit  = !win_good && ((bad_cnt + 1'b1) == BAD_W'(UNLOCK_CNT));
  assign clr_done    = clr_cnt == CLR_W'(CLR_CYCLES - 1);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      cur      <= ST_IDLE;
      nco_clr  <= 1'b0;
      locked   <= 1'b0;
      acq_fail <= 1'b0;
      kp_shift <= ACQ_KP;
      ki_shift <= ACQ_KI;
      acc      <= '0;
      smp_cnt  <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      win_cnt  <= '0;
      clr_cnt  <= '0;
    end else if (abort) begin
      // Abort beats start and any window-end decision in the same cycle.
      cur      <= ST_IDLE;
      nco_clr  <= 1'b0;
      locked   <= 1'b0;
      acq_fail <= 1'b0;
      kp_shift <= ACQ_KP;
      ki_shift <= ACQ_KI;
      acc      <= '0;
      smp_cnt  <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      win_cnt  <= '0;
      clr_cnt  <= '0;
    end else if (start) begin
      // Restart from any state: flush the loop and discard the partial window.
      cur      <= ST_CLEAR;
      nco_clr  <= 1'b1;
      locked   <= 1'b0;
      acq_fail <= 1'b0;
      kp_shift <= ACQ_KP;
      ki_shift <= ACQ_KI;
      acc      <= '0;
      smp_cnt  <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      win_cnt  <= '0;
      clr_cnt  <= '0;
    end else begin
      // Window accumulation; the sample after a window end starts a new one.
      if (err_valid && in_loop) begin
        if (win_end) begin
          acc     <= '0;
          smp_cnt <= '0;
        end else begin
          acc     <= acc_sum;
          smp_cnt <= smp_cnt + 1'b1;
        end
      end

      unique case (cur)
        ST_CLEAR: begin
          if (clr_done) begin
            cur     <= ST_ACQUIRE;
            nco_clr <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        ST_ACQUIRE: begin
          if (win_end) begin
            good_cnt <= win_good ? good_cnt + 1'b1 : '0;
            win_cnt  <= win_cnt + 1'b1;
            // Lock is checked first so it wins over a coincident timeout.
            if (lock_hit) begin
              cur      <= ST_TRACK;
              locked   <= 1'b1;
              kp_shift <= TRK_KP;
              ki_shift <= TRK_KI;
              good_cnt <= '0;
              win_cnt  <= '0;
            end else if (timeout_hit) begin
              cur      <= ST_FAIL;
              acq_fail <= 1'b1;
              good_cnt <= '0;
              win_cnt  <= '0;
            end
          end
        end

        ST_TRACK: begin
          if (win_end) begin
            bad_cnt <= win_good ? '0 : bad_cnt + 1'b1;
            if (unlock_hit) begin
              // Automatic relock: flush the loop and acquire again.
              cur      <= ST_CLEAR;
              nco_clr  <= 1'b1;
              locked   <= 1'b0;
              kp_shift <= ACQ_KP;
              ki_shift <= ACQ_KI;
              bad_cnt  <= '0;
              clr_cnt  <= '0;
            end
          end
        end

        default: ; // IDLE and FAIL wait for start/abort
      endcase
    end
  end

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_costas_lock_ctrl
//
// Directed bench for costas_lock_ctrl with WIN_LOG2=4. Stimulus pushes the
// expected output snapshot and the cycle on which it must appear into a queue;
// a monitor samples the outputs on every falling edge and, whenever they
// change, pops the next expectation and compares state, outputs and cycle.
// -----------------------------------------------------------------------------
module tb_costas_lock_ctrl;

  localparam int WIN_LOG2 = 4;
  localparam int SAMPLES  = 1 << WIN_LOG2;   // 16 samples per window
  localparam int CLR      = 16;              // default CLR_CYCLES

  typedef struct packed {
    logic [2:0] st;
    logic       lk;
    logic       af;
    logic       nc;
    logic [3:0] kp;
    logic [3:0] ki;
  } obs_t;

  typedef struct packed {
    int   cyc;
    obs_t o;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic               err_valid;
  logic signed [11:0] phase_err;
  logic               nco_clr;
  logic [3:0]         kp_shift;
  logic [3:0]         ki_shift;
  logic               locked;
  logic               acq_fail;
  logic [2:0]         state;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  costas_lock_ctrl #(.WIN_LOG2(WIN_LOG2)) dut (
    .CLK_IN    (clk),
    .RESET     (rst),
    .start     (start),
    .abort     (abort),
    .err_valid (err_valid),
    .phase_err (phase_err),
    .nco_clr   (nco_clr),
    .kp_shift  (kp_shift),
    .ki_shift  (ki_shift),
    .locked    (locked),
    .acq_fail  (acq_fail),
    .state     (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Expected outputs for each state, written out from the state definitions.
  function automatic obs_t model(int s);
    obs_t o;
    o = '{st: 3'(s), lk: 1'b0, af: 1'b0, nc: 1'b0, kp: 4'd4, ki: 4'd8};
    case (s)
      1: o.nc = 1'b1;
      3: begin o.lk = 1'b1; o.kp = 4'd7; o.ki = 4'd12; end
      4: o.af = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic push(int c, int s);
    exp_t e;
    e.cyc = c;
    e.o   = model(s);
    exp_q.push_back(e);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Valid sample every cycle, registered on edges cyc+1 .. end_cyc.
  task automatic drive_until(int end_cyc, logic signed [11:0] v0, logic signed [11:0] v1);
    err_valid = 1'b1;
    while (cyc < end_cyc) begin
      phase_err = cyc[0] ? v1 : v0;
      tick();
    end
    err_valid = 1'b0;
  endtask

  // Monitor: every output change must match the next queued expectation.
  obs_t prev = '{st: 3'd0, lk: 1'b0, af: 1'b0, nc: 1'b0, kp: 4'd4, ki: 4'd8};
  always @(negedge clk) begin
    obs_t cur;
    exp_t e;
    cur = '{st: state, lk: locked, af: acq_fail, nc: nco_clr, kp: kp_shift, ki: ki_shift};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got st=%0d lk=%0b af=%0b nc=%0b kp=%0d ki=%0d at cycle %0d, want no change",
                 cur.st, cur.lk, cur.af, cur.nc, cur.kp, cur.ki, cyc);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e.o || cyc != e.cyc) begin
          errors++;
          $display("FAIL transition: got st=%0d lk=%0b af=%0b nc=%0b kp=%0d ki=%0d at cycle %0d, want st=%0d lk=%0b af=%0b nc=%0b kp=%0d ki=%0d at cycle %0d",
                   cur.st, cur.lk, cur.af, cur.nc, cur.kp, cur.ki, cyc,
                   e.o.st, e.o.lk, e.o.af, e.o.nc, e.o.kp, e.o.ki, e.cyc);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int a;
    rst = 1'b1; start = 1'b0; abort = 1'b0; err_valid = 1'b0; phase_err = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Reset asserted between edges clears everything without a clock.
    t = cyc;
    push(t + 1, 1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    #1;
    push(cyc, 0);
    rst = 1'b1;
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_nco_clr", 32'(nco_clr), 0);
    check("rst_kp", 32'(kp_shift), 4);
    check("rst_ki", 32'(ki_shift), 8);
    check("rst_acq_fail", 32'(acq_fail), 0);
    tick();
    rst = 1'b0;
    tick();

    // Lock: +/-20 every cycle, CLEAR 16 cycles, TRACK after 64 samples.
    t = cyc;
    a = t + 1 + CLR;
    push(t + 1, 1);
    push(a, 2);
    push(a + 4 * SAMPLES, 3);
    start = 1'b1; err_valid = 1'b1; phase_err = 12'sd20;
    tick();
    start = 1'b0;
    drive_until(a + 4 * SAMPLES, 12'sd20, -12'sd20);
    check("lock_locked", 32'(locked), 1);

    // Loss of lock: bad, good (resets count), bad, bad -> CLEAR then ACQUIRE.
    t = cyc;
    push(t + 4 * SAMPLES, 1);
    push(t + 4 * SAMPLES + CLR, 2);
    drive_until(t + SAMPLES, 12'sd500, 12'sd500);
    drive_until(t + 2 * SAMPLES, 12'sd20, -12'sd20);
    drive_until(t + 4 * SAMPLES, 12'sd500, 12'sd500);
    while (cyc < t + 4 * SAMPLES + CLR) tick();

    // Abort coincident with the 4th good window end: IDLE, never locked.
    t = cyc;
    push(t + 4 * SAMPLES, 0);
    drive_until(t + 4 * SAMPLES - 1, 12'sd20, -12'sd20);
    abort = 1'b1; err_valid = 1'b1; phase_err = 12'sd20;
    tick();
    abort = 1'b0; err_valid = 1'b0;
    check("abort_locked", 32'(locked), 0);
    check("abort_state", 32'(state), 0);

    // start together with abort stays in IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_state", 32'(state), 0);
    tick();
    check("start_abort_nco", 32'(nco_clr), 0);

    // Saturation/timeout: -2048 forever -> FAIL after 64 windows.
    t = cyc;
    a = t + 1 + CLR;
    push(t + 1, 1);
    push(a, 2);
    push(a + 64 * SAMPLES, 4);
    start = 1'b1; err_valid = 1'b1; phase_err = -12'sd2048;
    tick();
    start = 1'b0;
    drive_until(a + 64 * SAMPLES, -12'sd2048, -12'sd2048);
    check("fail_acq_fail", 32'(acq_fail), 1);
    repeat (5) tick();
    check("fail_held", 32'(state), 4);

    // start from FAIL clears acq_fail and reacquires.
    t = cyc;
    push(t + 1, 1);
    push(t + 1 + CLR, 2);
    start = 1'b1; tick(); start = 1'b0;
    while (cyc < t + 1 + CLR) tick();

    // Gapped samples: valid every other cycle, lock after 64 valid samples.
    a = cyc;
    push(a + 8 * SAMPLES - 1, 3);
    for (int k = 0; k < 4 * SAMPLES; k++) begin
      err_valid = 1'b1;
      phase_err = k[0] ? -12'sd20 : 12'sd20;
      tick();
      err_valid = 1'b0;
      tick();
    end
    check("gap_locked", 32'(locked), 1);

    push(cyc + 1, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (2) tick();

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/costas_lock_ctrl.md
COSTAS_LOCK_CTRL -- requirements
Module: costas_lock_ctrl

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 8, log2 of samples per lock-detect window.
REQ-002 SHALL have parameter LOCK_THR, default 64, mean |phase error| threshold (LSB of phase_err).
REQ-003 SHALL have parameter LOCK_CNT, default 4, consecutive good windows needed to declare lock.
REQ-004 SHALL have parameter UNLOCK_CNT, default 2, consecutive bad windows needed to drop lock.
REQ-005 SHALL have parameter ACQ_TIMEOUT, default 64, windows allowed in ACQUIRE before failure.
REQ-006 SHALL have parameter CLR_CYCLES, default 16, cycles nco_clr is held in CLEAR.
REQ-007 SHALL have parameters ACQ_KP=4, ACQ_KI=8, TRK_KP=7, TRK_KI=12, the 4-bit gain shift values.
REQ-008 CLK_IN  in  1  single clock for all logic.
REQ-009 RESET  in  1  asynchronous, active-high reset.
REQ-010 start  in  1  single-cycle pulse to begin (re)acquisition.
REQ-011 abort  in  1  single-cycle pulse to stop the loop and return to IDLE.
REQ-012 err_valid  in  1  phase_err qualifier, one sample per high cycle.
REQ-013 phase_err  in  12  signed two's-complement Costas phase detector output.
REQ-014 nco_clr  out  1  clears the loop filter integrator and the NCO phase.
REQ-015 kp_shift  out  4  proportional gain right-shift for the loop filter.
REQ-016 ki_shift  out  4  integral gain right-shift for the loop filter.
REQ-017 locked  out  1  carrier lock indication.
REQ-018 acq_fail  out  1  acquisition timeout flag.
REQ-019 state  out  3  current state: IDLE=0, CLEAR=1, ACQUIRE=2, TRACK=3, FAIL=4.

Function
REQ-020 |phase_err| SHALL be computed with saturation, so -2048 maps to 2047 (11-bit unsigned).
REQ-021 The window accumulator SHALL be 11+WIN_LOG2 bits wide, SHALL never wrap, and SHALL add |phase_err| only on err_valid in ACQUIRE or TRACK.
REQ-022 A window SHALL end on the 2^WIN_LOG2-th valid sample; good = sum < (LOCK_THR << WIN_LOG2), evaluated including that sample.
REQ-023 At window end, the accumulator and sample counter SHALL restart at the next sample; no sample is dropped or double-counted.
REQ-024 IDLE: outputs at reset values; start -> CLEAR.
REQ-025 CLEAR: nco_clr=1 for exactly CLR_CYCLES cycles, window/good/bad/timeout counters zeroed, err_valid ignored; then -> ACQUIRE.
REQ-026 ACQUIRE: kp/ki = ACQ_KP/ACQ_KI; good window increments good_cnt, bad window zeroes it; good_cnt==LOCK_CNT -> TRACK; window count reaching ACQ_TIMEOUT without lock -> FAIL.
REQ-027 When lock and timeout occur on the same window end, lock SHALL win.
REQ-028 TRACK: locked=1, kp/ki = TRK_KP/TRK_KI; bad window increments bad_cnt, good window zeroes it; bad_cnt==UNLOCK_CNT -> CLEAR (automatic relock).
REQ-029 FAIL: acq_fail=1 and held; start -> CLEAR (acq_fail clears on entry); abort -> IDLE.
REQ-030 start in CLEAR, ACQUIRE or TRACK SHALL restart at CLEAR with counters zeroed.
REQ-031 abort in any state SHALL force IDLE on the next edge, with priority over start and any window-end decision.
REQ-032 The state transition and all outputs SHALL update on the clock edge that registers the window-ending sample (latency 1 cycle from sample to output).
REQ-033 All outputs SHALL be registered; locked and acq_fail SHALL be decoded from registered state only.

Reset
REQ-034 RESET high SHALL immediately, without a clock edge, set state=IDLE, nco_clr=0, locked=0, acq_fail=0, kp_shift=ACQ_KP, ki_shift=ACQ_KI, and zero all counters and the accumulator.
REQ-035 Reset asserted mid-operation SHALL discard any partial window; after release the block SHALL idle until start.

Verification (bench with WIN_LOG2=4, all other parameters at default)
REQ-036 Reset: RESET=1 between clock edges -> state=0, locked=0, nco_clr=0, kp_shift=4, ki_shift=8 immediately.
REQ-037 Lock: start, then phase_err alternating +20/-20, valid every cycle -> nco_clr high for 16 cycles, then state=2; locked=1, kp=7, ki=12 on the cycle after the 64th sample.
REQ-038 Saturation/timeout: phase_err=-2048 continuously -> accumulator reaches 16*2047 with no wrap, no lock; state=4 and acq_fail=1 after 64 windows (1024 samples).
REQ-039 Loss of lock: in TRACK, feed phase_err=500 for 32 samples -> locked falls and state=1 with nco_clr=1 after the 32nd sample; one good window in between resets the count.
REQ-040 Priority: abort coincident with the 4th good window end in ACQUIRE -> state=0, locked never asserts; start coincident with abort -> IDLE.
REQ-041 Gaps: err_valid toggled 1/0 -> windows count valid samples only; lock occurs after 64 valid samples (128 cycles).
